fifo_joiner2: RTL and testbench
===============================

Name: fifo_joiner2

Overview:
- Inverse of the stream splitter: merges two independent valid/ready streams into one output stream.
- Each output beat is the concatenation of exactly one token from input 1 and one from input 2.
- Sits where two producers must be paired before a consumer, e.g. activation plus error-delta feeding the weight-update path in backpropagation.
- One-entry holding slot per input plus one registered output stage; full throughput when downstream is ready.

Parameters:
- DATA1_WIDTH, 32, width of data_in1.
- DATA2_WIDTH, 32, width of data_in2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- data_in1  in  DATA1_WIDTH  stream 1 payload.
- data_in1_valid  in  1  stream 1 valid.
- data_in1_ready  out  1  stream 1 ready.
- data_in2  in  DATA2_WIDTH  stream 2 payload.
- data_in2_valid  in  1  stream 2 valid.
- data_in2_ready  out  1  stream 2 ready.
- data_out  out  DATA1_WIDTH+DATA2_WIDTH  {data1, data2}; data1 in the MSBs.
- data_out_valid  out  1  output valid.
- data_out_ready  in  1  output ready.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid & ready are both 1. Producers may not drop valid or change data before transfer. The block never drops out valid or changes data_out while data_out_valid=1 and data_out_ready=0.
- Per-input slot state: EMPTY or HELD (flag fullX, register bufX).
- Output stage state: IDLE or VALID (flag data_out_valid, register data_out).
- Internal signal move = full1 & full2 & (~data_out_valid | data_out_ready).
- On move: data_out <= {buf1, buf2}, data_out_valid <= 1, full1 <= 0, full2 <= 0.
- Output stage when no move: data_out_valid cleared on an output transfer, otherwise held.
- data_inX_ready = rst & (~fullX | move). This is combinational from data_out_ready by design; the consumer must not make data_out_ready depend combinationally on data_inX_ready.
- Slot capture: on an input transfer, bufX <= data_inX and fullX <= 1. Capture in the same cycle as move leaves the slot HELD with the new token.
- Latency: both tokens accepted at edge N -> data_out_valid=1 after edge N+1. With all valids and ready held high, one output per cycle after fill.
- Skewed arrival: a token that arrives early is held indefinitely. Its input's ready stays 0 until the partner arrives and move fires. No token is ever dropped or duplicated.
- Output stalled (VALID & ~data_out_ready) with both slots HELD: both readies = 0 and all state is frozen.
- Reset (rst=0, any time, asynchronous):
  - full1 = full2 = data_out_valid = 0.
  - data_out = 0; buffers cleared to 0.
  - Both readies = 0 while rst=0. In-flight tokens are discarded.
  - The first edge after deassertion behaves as from an empty state.
- Widths: pure concatenation, no arithmetic; no truncation or extension.

Decomposition:
- Shared header: default stream width constant (32), shared with fifo_splitter2.
- Sub-module fifo_slot (parameter DATA_WIDTH):
  - one-entry register with full flag, in valid/ready, and a "take" input driven by move;
  - instantiated twice.
- Top level holds the move logic and the output register.

Test Plan:
1. Reset: rst=0 with random inputs -> data_out_valid=0, data_out=0, both readies=0. Release rst; next cycle both readies=1.
2. Basic pair, data_out_ready=1:
   - stimulus: data_in1=666 and data_in2=777, valid for one accepted beat each, same edge N;
   - response: after edge N+1, data_out={666,777} with valid=1 for exactly one cycle.
3. Skew: only stream 1 sends 666; stream 2 sends 777 ten cycles later.
   - data_in1_ready=0 throughout the wait; exactly one output {666,777}.
   - A second stream-1 token (111) offered during the wait is not accepted until move.
4. Backpressure: data_out_ready=0 with pairs (1,2) and (3,4) offered.
   - First pair is held stable on data_out; the second pair fills the slots; both readies drop to 0.
   - Raise ready -> outputs {1,2} then {3,4} on consecutive cycles.
5. Streaming: both inputs send 0..15 back-to-back with ready=1 -> 16 outputs {i,i} on 16 consecutive cycles, no bubbles.
6. Mid-operation reset:
   - stimulus: pulse rst=0 while a slot is HELD (666) and data_out_valid=1;
   - response: all flags clear immediately without a clock edge, and the held 666 is never emitted after reset.

Source files
------------

// File: rtl/fifo_joiner2_pkg.sv
// fifo_joiner2_pkg: stream width shared by the joiner/splitter pair
package fifo_joiner2_pkg;
    localparam int STREAM_WIDTH = 32;
endpackage

// File: rtl/fifo_slot.sv
// fifo_slot: one-entry holding register with full flag; take empties it
// Ports: clk, rst (async, active-low); data_in/in_valid/in_ready = upstream
// stream; take = slot contents consumed this edge; full/data = held token.
module fifo_slot
    import fifo_joiner2_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  take,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data
);
    logic capture;
    // a slot being taken can refill on the same edge
    assign in_ready = rst & (~full | take);
    assign capture  = in_valid & in_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (capture) begin
            full <= 1'b1;
            data <= data_in;
        end else if (take) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/fifo_joiner2.sv
// fifo_joiner2: pairs one token from each of two streams into one output beat
// Ports: clk, rst (async, active-low); data_in1/2 + valid/ready = input
// streams; data_out = {data1, data2} with data_out_valid/data_out_ready.
// Input readies depend combinationally on data_out_ready.
module fifo_joiner2
    import fifo_joiner2_pkg::*;
#(
    parameter int DATA1_WIDTH = STREAM_WIDTH,
    parameter int DATA2_WIDTH = STREAM_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA1_WIDTH-1:0]           data_in1,
    input  logic                             data_in1_valid,
    output logic                             data_in1_ready,
    input  logic [DATA2_WIDTH-1:0]           data_in2,
    input  logic                             data_in2_valid,
    output logic                             data_in2_ready,
    output logic [DATA1_WIDTH+DATA2_WIDTH-1:0] data_out,
    output logic                             data_out_valid,
    input  logic                             data_out_ready
);
    logic                   full1, full2, move;
    logic [DATA1_WIDTH-1:0] buf1;
    logic [DATA2_WIDTH-1:0] buf2;
    assign move = full1 & full2 & (~data_out_valid | data_out_ready);
    fifo_slot #(.DATA_WIDTH(DATA1_WIDTH)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in1),
        .in_valid (data_in1_valid),
        .in_ready (data_in1_ready),
        .take     (move),
        .full     (full1),
        .data     (buf1)
    );
    fifo_slot #(.DATA_WIDTH(DATA2_WIDTH)) u_slot2 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in2),
        .in_valid (data_in2_valid),
        .in_ready (data_in2_ready),
        .take     (move),
        .full     (full2),
        .data     (buf2)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (move) begin
            data_out       <= {buf1, buf2};
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_joiner2.sv
// tb_fifo_joiner2: randomized and directed checks against a queue-based pairing model
module tb_fifo_joiner2;
    logic        clk = 0, rst = 0;
    logic [31:0] d1 = 0, d2 = 0;
    logic        v1 = 0, v2 = 0, r1, r2, ov, ordy = 0;
    logic [63:0] od;
    int          checks = 0, errors = 0;
    logic [31:0] q1[$], q2[$];
    logic [63:0] eq[$];
    logic        acc1 = 0, acc2 = 0, prev_stall = 0;
    logic [63:0] prev_data = 0;

    fifo_joiner2 dut (
        .clk(clk), .rst(rst),
        .data_in1(d1), .data_in1_valid(v1), .data_in1_ready(r1),
        .data_in2(d2), .data_in2_valid(v2), .data_in2_ready(r2),
        .data_out(od), .data_out_valid(ov), .data_out_ready(ordy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [31:0] a, b;
        logic [63:0] e;
        @(negedge clk);
        if (!rst) begin
            q1.delete(); q2.delete(); eq.delete();
            prev_stall = 0; acc1 = 0; acc2 = 0;
        end else begin
            acc1 = v1 && r1;
            acc2 = v2 && r2;
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || od !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", ov, od, prev_data);
                end
            end
            if (ov && ordy) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data=%h required no output", od);
                end else begin
                    e = eq.pop_front();
                    if (od !== e) begin
                        errors++;
                        $display("FAIL output_data: got %h required %h", od, e);
                    end
                end
            end
            prev_stall = ov && !ordy;
            prev_data  = od;
            if (acc1) q1.push_back(d1);
            if (acc2) q2.push_back(d2);
            while (q1.size() > 0 && q2.size() > 0) begin
                a = q1.pop_front();
                b = q2.pop_front();
                eq.push_back({a, b});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d1 = $urandom; d2 = $urandom; v1 = 1; v2 = 1; ordy = 1;
        #1;
        checks++;
        if (ov !== 0 || od !== 64'd0 || r1 !== 0 || r2 !== 0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h r1=%b r2=%b required 0 0 0 0", ov, od, r1, r2);
        end
        tick();
        v1 = 0; v2 = 0; rst = 1;
        tick();
        checks++;
        if (r1 !== 1 || r2 !== 1 || ov !== 0) begin
            errors++;
            $display("FAIL reset_release: r1=%b r2=%b valid=%b required 1 1 0", r1, r2, ov);
        end
    endtask

    task automatic test_basic();
        ordy = 1; d1 = 666; d2 = 777; v1 = 1; v2 = 1;
        tick();
        v1 = 0; v2 = 0;
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL basic_latency: valid=%b required 0", ov); end
        tick();
        checks++;
        if (ov !== 1 || od !== {32'd666, 32'd777}) begin
            errors++;
            $display("FAIL basic_pair: valid=%b data=%h required 1 %h", ov, od, {32'd666, 32'd777});
        end
        tick();
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL basic_single: valid=%b required 0", ov); end
    endtask

    task automatic test_skew();
        ordy = 1; d1 = 666; v1 = 1;
        tick();
        d1 = 111;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (r1 !== 0) begin errors++; $display("FAIL skew_wait_ready: cycle %0d r1=%b required 0", i, r1); end
            tick();
        end
        d2 = 777; v2 = 1;
        checks++;
        if (r1 !== 0 || r2 !== 1) begin
            errors++;
            $display("FAIL skew_partner: r1=%b r2=%b required 0 1", r1, r2);
        end
        tick();
        v2 = 0;
        checks++;
        if (r1 !== 1) begin errors++; $display("FAIL skew_move_ready: r1=%b required 1", r1); end
        tick();
        v1 = 0;
        checks++;
        if (ov !== 1 || od !== {32'd666, 32'd777}) begin
            errors++;
            $display("FAIL skew_pair: valid=%b data=%h required 1 %h", ov, od, {32'd666, 32'd777});
        end
        tick();
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL skew_once: valid=%b required 0", ov); end
        d2 = 5; v2 = 1;
        tick();
        v2 = 0;
        tick();
        checks++;
        if (ov !== 1 || od !== {32'd111, 32'd5}) begin
            errors++;
            $display("FAIL skew_second: valid=%b data=%h required 1 %h", ov, od, {32'd111, 32'd5});
        end
        tick();
    endtask

    task automatic test_backpressure();
        ordy = 0; d1 = 1; d2 = 2; v1 = 1; v2 = 1;
        tick();
        d1 = 3; d2 = 4;
        tick();
        v1 = 0; v2 = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov !== 1 || od !== {32'd1, 32'd2} || r1 !== 0 || r2 !== 0) begin
                errors++;
                $display("FAIL bp_stall: valid=%b data=%h r1=%b r2=%b required 1 %h 0 0", ov, od, r1, r2, {32'd1, 32'd2});
            end
            tick();
        end
        ordy = 1;
        tick();
        checks++;
        if (ov !== 1 || od !== {32'd3, 32'd4}) begin
            errors++;
            $display("FAIL bp_second: valid=%b data=%h required 1 %h", ov, od, {32'd3, 32'd4});
        end
        tick();
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL bp_drain: valid=%b required 0", ov); end
    endtask

    task automatic test_streaming();
        logic [31:0] p;
        ordy = 1;
        for (int i = 0; i < 16; i++) begin
            d1 = i; d2 = i; v1 = 1; v2 = 1;
            checks++;
            if (r1 !== 1 || r2 !== 1) begin errors++; $display("FAIL stream_ready: beat %0d r1=%b r2=%b required 1 1", i, r1, r2); end
            tick();
            if (i > 0) begin
                p = i - 1;
                checks++;
                if (ov !== 1 || od !== {p, p}) begin
                    errors++;
                    $display("FAIL stream_out: beat %0d valid=%b data=%h required 1 %h", i, ov, od, {p, p});
                end
            end
        end
        v1 = 0; v2 = 0;
        tick();
        checks++;
        if (ov !== 1 || od !== {32'd15, 32'd15}) begin
            errors++;
            $display("FAIL stream_last: valid=%b data=%h required 1 %h", ov, od, {32'd15, 32'd15});
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if (!v1 || acc1) begin v1 = $urandom_range(0, 1); d1 = $urandom; end
            if (!v2 || acc2) begin v2 = $urandom_range(0, 1); d2 = $urandom; end
            ordy = $urandom_range(0, 3) != 0;
            tick();
        end
        v1 = 0; v2 = 0; ordy = 1;
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (eq.size() != 0) begin errors++; $display("FAIL random_drain: %0d pairs pending required 0", eq.size()); end
    endtask

    task automatic test_midreset();
        ordy = 0; d1 = 9; d2 = 9; v1 = 1; v2 = 1;
        tick();
        d1 = 666; v2 = 0;
        tick();
        v1 = 0;
        checks++;
        if (ov !== 1 || r1 !== 0) begin errors++; $display("FAIL midreset_setup: valid=%b r1=%b required 1 0", ov, r1); end
        #2 rst = 0;
        #1;
        checks++;
        if (ov !== 0 || od !== 64'd0 || r1 !== 0 || r2 !== 0) begin
            errors++;
            $display("FAIL midreset_async: valid=%b data=%h r1=%b r2=%b required 0 0 0 0", ov, od, r1, r2);
        end
        tick();
        rst = 1; ordy = 1; d1 = 50; d2 = 8; v1 = 1; v2 = 1;
        tick();
        v1 = 0; v2 = 0;
        tick();
        checks++;
        if (ov !== 1 || od !== {32'd50, 32'd8}) begin
            errors++;
            $display("FAIL midreset_after: valid=%b data=%h required 1 %h", ov, od, {32'd50, 32'd8});
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_backpressure();
        test_streaming();
        test_random();
        test_midreset();
        checks++;
        if (eq.size() != 0) begin errors++; $display("FAIL final_drain: %0d pairs pending required 0", eq.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
